// File: rtl/pc_sequencer.sv
// Program-counter sequencer: arm on start, run from START_PC to END_PC with stall/jump/halt control.
// Relative jumps are only honoured when PC_SEQ_REL_JUMP_EN is defined; otherwise rel_jump/offset are ignored.
//
// state | meaning
// IDLE  | after reset, waiting for start
// ARMED | prog_ct loaded with START_PC, waiting for start to fall
// RUN   | counter advancing, cycle_ct counting
// DONE  | run finished (END_PC or halt), values held until next start
module pc_sequencer #(
    parameter int PC_W     = 10,
    parameter int START_PC = 0,
    parameter int END_PC   = 10,
    parameter int OFF_W    = 6,
    parameter int CYC_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic             stall,
    input  logic             abs_jump,
    input  logic [PC_W-1:0]  target,
    input  logic             rel_jump,
    input  logic [OFF_W-1:0] offset,
    output logic [PC_W-1:0]  prog_ct,
    output logic             running,
    output logic             done,
    output logic [CYC_W-1:0] cycle_ct
);

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

    localparam logic [PC_W-1:0] START_V = PC_W'(START_PC);
    localparam logic [PC_W-1:0] END_V   = PC_W'(END_PC);

    state_t           state, state_nxt;
    logic [PC_W-1:0]  pc_nxt;
    logic [CYC_W-1:0] cyc_nxt;
    logic             rel_go;
    logic [PC_W-1:0]  rel_delta;

`ifdef PC_SEQ_REL_JUMP_EN
    // sign-extend past PC_W so the add below wraps modulo 2^PC_W for any OFF_W
    logic [PC_W+OFF_W-1:0] off_ext;
    assign off_ext   = {{PC_W{offset[OFF_W-1]}}, offset};
    assign rel_go    = rel_jump;
    assign rel_delta = off_ext[PC_W-1:0];
`else
    wire unused_rel = &{1'b0, rel_jump, offset};
    assign rel_go    = 1'b0;
    assign rel_delta = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            prog_ct  <= '0;
            cycle_ct <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            prog_ct  <= pc_nxt;
            cycle_ct <= cyc_nxt;
            running  <= (state_nxt == RUN);
            done     <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = prog_ct;
        cyc_nxt   = cycle_ct;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = ARMED;
                    pc_nxt    = START_V;
                    cyc_nxt   = '0;
                end
            end
            ARMED: begin
                if (!start) state_nxt = RUN;
            end
            RUN: begin
                if (cycle_ct != '1) cyc_nxt = cycle_ct + CYC_W'(1);
                if (halt) begin
                    state_nxt = DONE;
                end else if (stall) begin
                    pc_nxt = prog_ct;
                end else if (prog_ct == END_V) begin
                    state_nxt = DONE;
                end else if (abs_jump) begin
                    pc_nxt = target;
                end else if (rel_go) begin
                    pc_nxt = prog_ct + rel_delta;
                end else begin
                    pc_nxt = prog_ct + PC_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
